// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - registered ALU control decode with iterative shift micro-op issue
//
// Accepts one instruction per in_valid/in_ready handshake, decodes the 5-bit opcode
// (instr[INSTR_W-1 -: 5]) into a one-hot ALU op, and issues micro-ops on an
// out_valid/out_ready handshake. With ITER_SHIFT=1 a shift of k>=2 becomes k
// single-bit micro-ops.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake (in_ready is combinational)
//   instr, no_flags     instruction word, flag-update suppression
//   out_valid/out_ready micro-op handshake
//   alu_op              one-hot ALU op (0 = non-ALU instruction)
//   shift_amt           shift distance of this micro-op
//   flag_en             update flags with this micro-op's result
//   last                final micro-op of the instruction
module alu_op_sequencer #(
    parameter int INSTR_W    = 16,
    parameter int SHAMT_W    = 4,
    parameter int ITER_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               no_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         alu_op,
    output logic [SHAMT_W-1:0] shift_amt,
    output logic               flag_en,
    output logic               last
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [6:0] OP_ADD = 7'b0000001;
    localparam logic [6:0] OP_SUB = 7'b0000010;
    localparam logic [6:0] OP_AND = 7'b0000100;
    localparam logic [6:0] OP_OR  = 7'b0001000;
    localparam logic [6:0] OP_NOT = 7'b0010000;
    localparam logic [6:0] OP_SHR = 7'b0100000;
    localparam logic [6:0] OP_SHL = 7'b1000000;

    logic [1:0]         state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [6:0]         alu_op_q, alu_op_d;
    logic [SHAMT_W-1:0] shift_amt_q, shift_amt_d;
    logic               flag_en_q, flag_en_d;
    logic               last_q, last_d;
    logic               nf_q, nf_d;

    logic [4:0]         opc;
    logic [SHAMT_W-1:0] shamt;
    logic [6:0]         dec_op;
    logic               is_shift;
    logic               multi;
    logic               accept;
    logic               unused_instr_bits;

    assign opc               = instr[INSTR_W-1 -: 5];
    assign shamt             = instr[SHAMT_W-1:0];
    assign unused_instr_bits = ^instr;

    // Priority decode, top entry wins.
    always_comb begin
        dec_op = 7'b0;
        if (opc[4:1] == 4'b1000)                          dec_op = OP_SUB;
        else if (opc == 5'b10011)                         dec_op = OP_AND;
        else if (opc == 5'b10010)                         dec_op = OP_OR;
        else if (opc == 5'b10110)                         dec_op = OP_NOT;
        else if (opc == 5'b10101)                         dec_op = OP_SHR;
        else if (opc == 5'b10100)                         dec_op = OP_SHL;
        else if (opc[4:3] == 2'b00 || opc[4:3] == 2'b01)  dec_op = OP_ADD;
        else if (opc[4:3] == 2'b11 && opc[2:0] != 3'b111) dec_op = OP_ADD;
        else                                              dec_op = 7'b0;
    end

    assign is_shift  = (dec_op == OP_SHR) || (dec_op == OP_SHL);
    assign multi     = (ITER_SHIFT != 0) && is_shift && (shamt > SHAMT_W'(1));

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_ISSUE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        alu_op_d    = alu_op_q;
        shift_amt_d = shift_amt_q;
        flag_en_d   = flag_en_q;
        last_d      = last_q;
        nf_d        = nf_q;
        if (accept) begin
            alu_op_d = dec_op;
            nf_d     = no_flags;
            if (multi) begin
                state_d     = S_REPEAT;
                count_d     = shamt - SHAMT_W'(1);
                shift_amt_d = SHAMT_W'(1);
                last_d      = 1'b0;
                flag_en_d   = 1'b0;
            end else begin
                state_d     = S_ISSUE;
                count_d     = '0;
                shift_amt_d = is_shift ? shamt : '0;
                last_d      = 1'b1;
                flag_en_d   = !no_flags && (dec_op != 7'b0);
            end
        end else if (state_q == S_ISSUE && out_ready) begin
            // Final micro-op consumed with nothing waiting: go idle with clean outputs.
            state_d     = S_IDLE;
            alu_op_d    = '0;
            shift_amt_d = '0;
            flag_en_d   = 1'b0;
            last_d      = 1'b0;
        end else if (state_q == S_REPEAT && out_ready) begin
            count_d = count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) begin
                // The next micro-op is the final one; flags apply only there.
                state_d   = S_ISSUE;
                last_d    = 1'b1;
                flag_en_d = !nf_q && (alu_op_q != 7'b0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            alu_op_q    <= '0;
            shift_amt_q <= '0;
            flag_en_q   <= 1'b0;
            last_q      <= 1'b0;
            nf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            alu_op_q    <= alu_op_d;
            shift_amt_q <= shift_amt_d;
            flag_en_q   <= flag_en_d;
            last_q      <= last_d;
            nf_q        <= nf_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign shift_amt = shift_amt_q;
    assign flag_en   = flag_en_q;
    assign last      = last_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] instr;
    logic        no_flags;
    logic        out_ready;

    logic        in_ready, out_valid, flag_en, last;
    logic [6:0]  alu_op;
    logic [3:0]  shift_amt;

    logic        in_ready1, out_valid1, flag_en1, last1;
    logic [6:0]  alu_op1;
    logic [3:0]  shift_amt1;

    always #5 clk = ~clk;

    alu_op_sequencer #(.INSTR_W(16), .SHAMT_W(4), .ITER_SHIFT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .no_flags(no_flags), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .shift_amt(shift_amt), .flag_en(flag_en), .last(last)
    );

    alu_op_sequencer #(.INSTR_W(16), .SHAMT_W(4), .ITER_SHIFT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .instr(instr), .no_flags(no_flags), .out_valid(out_valid1), .out_ready(out_ready),
        .alu_op(alu_op1), .shift_amt(shift_amt1), .flag_en(flag_en1), .last(last1)
    );

    localparam logic [6:0] ADD = 7'h01, SUB = 7'h02, AND_ = 7'h04, OR_ = 7'h08;
    localparam logic [6:0] NOT_ = 7'h10, SHR = 7'h20, SHL = 7'h40;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0] op;
        logic [3:0] amt;
        logic       lst;
        logic       flg;
    } uop_t;

    uop_t q[$];

    typedef struct {
        logic [15:0] ins;
        logic        nf;
        logic [6:0]  exp_op;
        logic [3:0]  exp_amt;
        int          exp_n;
        logic        exp_flg;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_op(input logic [4:0] o);
        if (o[4:1] == 4'b1000) return SUB;
        if (o == 5'b10011) return AND_;
        if (o == 5'b10010) return OR_;
        if (o == 5'b10110) return NOT_;
        if (o == 5'b10101) return SHR;
        if (o == 5'b10100) return SHL;
        if (o[4:3] != 2'b10 && o != 5'b11111) return ADD;
        return 7'h00;
    endfunction

    // Expand an accepted instruction into the micro-ops it must produce.
    task automatic push_instr(input logic [15:0] i, input logic nf);
        logic [6:0] op;
        int         k;
        bit         sh;
        op = ref_op(i[15:11]);
        k  = int'(i[3:0]);
        sh = (op == SHR) || (op == SHL);
        if (sh && k >= 2) begin
            for (int j = 0; j < k; j++)
                q.push_back({op, 4'd1, j == k - 1, (j == k - 1) && !nf});
        end else begin
            q.push_back({op, sh ? i[3:0] : 4'd0, 1'b1, !nf && (op != 7'h00)});
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, update model at posedge.
    task automatic cycle(input logic iv, input logic [15:0] ins, input logic nf, input logic ordy);
        bit   exp_v, exp_r;
        uop_t act;
        in_valid  = iv;
        instr     = ins;
        no_flags  = nf;
        out_ready = ordy;
        @(negedge clk);
        exp_v = q.size() > 0;
        exp_r = (q.size() == 0) || (q.size() == 1 && ordy);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_r});
        if (exp_v && out_valid) begin
            act = {alu_op, shift_amt, last, flag_en};
            chk("uop{op,amt,last,flag}", {19'b0, act}, {19'b0, q[0]});
        end
        @(posedge clk);
        if (exp_v && ordy) void'(q.pop_front());
        if (iv && exp_r) push_instr(ins, nf);
        #1;
    endtask

    vec_t vt[16];
    int   n;
    bit   done;

    initial begin
        vt[0]  = '{16'h0123, 1'b0, ADD,   4'd0, 1,  1'b1};
        vt[1]  = '{16'hA003, 1'b0, SHL,   4'd1, 3,  1'b1};
        vt[2]  = '{16'h8000, 1'b0, SUB,   4'd0, 1,  1'b1};
        vt[3]  = '{16'h9800, 1'b1, AND_,  4'd0, 1,  1'b0};
        vt[4]  = '{16'h9000, 1'b0, OR_,   4'd0, 1,  1'b1};
        vt[5]  = '{16'hB000, 1'b1, NOT_,  4'd0, 1,  1'b0};
        vt[6]  = '{16'hA804, 1'b0, SHR,   4'd1, 4,  1'b1};
        vt[7]  = '{16'hA001, 1'b0, SHL,   4'd1, 1,  1'b1};
        vt[8]  = '{16'hA000, 1'b0, SHL,   4'd0, 1,  1'b1};
        vt[9]  = '{16'hF800, 1'b0, 7'h00, 4'd0, 1,  1'b0};
        vt[10] = '{16'hB800, 1'b0, 7'h00, 4'd0, 1,  1'b0};
        vt[11] = '{16'hE000, 1'b0, ADD,   4'd0, 1,  1'b1};
        vt[12] = '{16'h4000, 1'b0, ADD,   4'd0, 1,  1'b1};
        vt[13] = '{16'h8805, 1'b0, SUB,   4'd0, 1,  1'b1};
        vt[14] = '{16'hAFFF, 1'b0, SHR,   4'd1, 15, 1'b1};
        vt[15] = '{16'h2FFF, 1'b1, ADD,   4'd0, 1,  1'b0};

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; no_flags = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst alu_op", {25'b0, alu_op}, 32'd0);
        chk("rst shift_amt", {28'b0, shift_amt}, 32'd0);
        chk("rst flag_en", {31'b0, flag_en}, 32'd0);
        chk("rst last", {31'b0, last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SHL by 3 iterated on u0, single full-amount micro-op on u1; ADD waits behind it.
        cycle(1'b1, 16'hA003, 1'b0, 1'b1);
        chk("u1 out_valid", {31'b0, out_valid1}, 32'd1);
        chk("u1 alu_op", {25'b0, alu_op1}, {25'b0, SHL});
        chk("u1 shift_amt", {28'b0, shift_amt1}, 32'd3);
        chk("u1 last", {31'b0, last1}, 32'd1);
        chk("u1 flag_en", {31'b0, flag_en1}, 32'd1);
        chk("u1 in_ready", {31'b0, in_ready1}, 32'd1);
        cycle(1'b1, 16'h0123, 1'b0, 1'b1);
        cycle(1'b1, 16'h0123, 1'b0, 1'b1);
        cycle(1'b1, 16'h0123, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // SUB then AND with a 2-cycle stall: SUB held, AND follows without a bubble.
        cycle(1'b1, 16'h8000, 1'b0, 1'b1);
        cycle(1'b1, 16'h9800, 1'b0, 1'b0);
        cycle(1'b1, 16'h9800, 1'b0, 1'b0);
        cycle(1'b1, 16'h9800, 1'b0, 1'b1);
        chk("AND after SUB", {25'b0, alu_op}, {25'b0, AND_});
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Stall in the middle of an iterated shift.
        cycle(1'b1, 16'hA403, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b1, 16'h8000, 1'b0, 1'b1);
        cycle(1'b1, 16'h8000, 1'b0, 1'b0);
        cycle(1'b1, 16'h8000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Decode table, each instruction drained with out_ready held high.
        for (int v = 0; v < 16; v++) begin
            cycle(1'b1, vt[v].ins, vt[v].nf, 1'b1);
            in_valid = 1'b0;
            n = 0;
            done = 0;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge clk);
                if (!out_valid) begin
                    done = 1;
                end else begin
                    n++;
                    chk("tbl alu_op", {25'b0, alu_op}, {25'b0, vt[v].exp_op});
                    if (n == 1) chk("tbl shift_amt", {28'b0, shift_amt}, {28'b0, vt[v].exp_amt});
                    if (last) begin
                        chk("tbl flag_en", {31'b0, flag_en}, {31'b0, vt[v].exp_flg});
                        done = 1;
                    end else begin
                        chk("tbl early flag_en", {31'b0, flag_en}, 32'd0);
                    end
                    @(posedge clk); #1;
                end
            end
            chk("tbl uop count", n, vt[v].exp_n);
            if (!done) $display("FAIL tbl drain timeout actual=%0d required=%0d", n, vt[v].exp_n);
            if (done && out_valid) @(posedge clk);
            q.delete();
            @(posedge clk); #1;
        end

        // Reset during the 2nd micro-op of SHR by 4.
        cycle(1'b1, 16'hA804, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 16'h0123, 1'b0, 1'b1);
        chk("post rst last", {31'b0, last}, 32'd1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Random traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ri[15:11] = ($urandom_range(0, 1) == 0) ? 5'b10101 : 5'b10100;
            cycle(1'($urandom_range(0, 1)), ri, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
